// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode hex display driver with frame-synchronous double buffering.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d, pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  bnd_q, bnd_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d, blank;
    logic                  frame_tick_q, frame_tick_d;
    logic                  tc;
    logic [3:0]            digit;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  run;
`endif

    always_comb begin
        tc           = pre_q == PRE_LAST;
        bnd_d        = tc && idx_q == IDX_LAST;
        pre_d        = tc ? '0 : pre_q + 1'b1;
        idx_d        = tc ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        disp_d       = bnd_d && pend_valid_q ? pend_q : disp_q;
        pend_d       = load ? value : pend_q;
        pend_valid_d = load || (pend_valid_q && !bnd_d);
        digit        = 4'(disp_q >> {idx_q, 2'b00});
        blank        = '0;
`ifdef LEADING_ZERO_BLANK_EN
        run          = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run      = run && disp_q[4*i +: 4] == 4'h0;
            blank[i] = run;
        end
`endif
        seg_d        = blank[idx_q] ? 7'h7F : GLYPH[digit];
        an_d         = ~(DIGITS'(1) << idx_q);
        // Delayed one extra cycle so the tick lines up with the first new digit on seg.
        frame_tick_d = bnd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            bnd_q        <= 1'b0;
            seg_q        <= 7'h7F;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            bnd_q        <= bnd_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: table-driven, scenario and randomized checks against an edge-count reference model.
module tb_seven_seg_scanner;
    localparam int D = 4;
    localparam int R = 4;
    localparam int F = D * R;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h7F;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif
    localparam logic [6:0] GL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic       r;
        logic [6:0] seg;
        logic [3:0] an;
        logic       ft;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic        m_pv = 1'b0;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    logic        m_ft;
    vec_t        tbl [20];
    logic [3:0]  an_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    // Highest nonzero digit bounds what is shown; everything above it is a leading zero.
    function automatic logic [6:0] glyph_of(input logic [15:0] v, input int i);
`ifdef LEADING_ZERO_BLANK_EN
        int h = 0;
        for (int j = 0; j < D; j++) if (v[4*j +: 4] != 4'h0) h = j;
        if (i > h) return 7'h7F;
`endif
        return GL[v[4*i +: 4]];
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] v);
        int ip;
        rst = r; load = l; value = v;
        @(posedge clk); #1;
        if (r) begin
            k = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
            m_seg = 7'h7F; m_an = 4'hF; m_ft = 1'b0;
        end else begin
            k++;
            ip    = ((k - 1) / R) % D;
            m_seg = glyph_of(m_disp, ip);
            m_an  = ~(4'(1) << ip);
            m_ft  = (k > 1) && ((k - 1) % F == 0);
            if (k % F == 0 && m_pv) begin m_disp = m_pend; m_pv = 1'b0; end
            if (l) begin m_pend = v; m_pv = 1'b1; end
        end
        chk("seg", 16'(seg), 16'(m_seg));
        chk("an", 16'(an), 16'(m_an));
        chk("frame_tick", 16'(frame_tick), 16'(m_ft));
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 7'h7F, 4'hF, 1'b0};
        tbl[1] = '{1'b1, 7'h7F, 4'hF, 1'b0};
        for (int i = 0; i < 18; i++)
            tbl[i+2] = '{1'b0, (i / 4 == 0 || i / 4 == 4) ? 7'h40 : ZB, an_seq[i/4], i == 16};
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, 1'b0, 16'h0);
            chk("tbl_seg", 16'(seg), 16'(tbl[i].seg));
            chk("tbl_an", 16'(an), 16'(tbl[i].an));
            chk("tbl_ft", 16'(frame_tick), 16'(tbl[i].ft));
        end

        run_to(19); step(1'b0, 1'b1, 16'h12AF);
        run_to(29); chk("no_tear", 16'(seg), 16'(ZB));
        run_to(33); chk("ld_d0", 16'(seg), 16'h0E); chk("ld_tick", 16'(frame_tick), 16'h1);
        run_to(37); chk("ld_d1", 16'(seg), 16'h08);
        run_to(41); chk("ld_d2", 16'(seg), 16'h24);
        run_to(45); chk("ld_d3", 16'(seg), 16'h79); chk("ld_an3", 16'(an), 16'h7);

        run_to(49); step(1'b0, 1'b1, 16'h1111);
        run_to(54); step(1'b0, 1'b1, 16'h2222);
        run_to(65); chk("last_load_wins", 16'(seg), 16'h24);

        run_to(69); step(1'b0, 1'b1, 16'h1111);
        run_to(79); step(1'b0, 1'b1, 16'h3333);
        run_to(81); chk("bnd_old_pending", 16'(seg), 16'h79);
        run_to(97); chk("bnd_new_pending", 16'(seg), 16'h30);

        run_to(99); step(1'b0, 1'b1, 16'h0050);
        run_to(113); chk("z_d0", 16'(seg), 16'h40);
        run_to(117); chk("z_d1", 16'(seg), 16'h12);
        run_to(121); chk("z_d2", 16'(seg), 16'(ZB));
        run_to(125); chk("z_d3", 16'(seg), 16'(ZB));
        step(1'b0, 1'b1, 16'h0000);
        run_to(129); chk("zero_d0", 16'(seg), 16'h40);
        run_to(133); chk("zero_d1", 16'(seg), 16'(ZB));

        run_to(134); step(1'b0, 1'b1, 16'hABCD);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_seg", 16'(seg), 16'h7F); chk("rst_an", 16'(an), 16'hF);
        step(1'b0, 1'b0, 16'h0);
        chk("rel_seg", 16'(seg), 16'h40); chk("rel_an", 16'(an), 16'hE);
        run_to(17); chk("discard_seg", 16'(seg), 16'h40); chk("discard_tick", 16'(frame_tick), 16'h1);
        run_to(40);

        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
